// File: rtl/raster_pixel_streamer_pkg.sv
// Shared types and sizing helpers for the raster pixel streamer and its output FIFO.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } sideband_t;

   // BT.601-style luma weights scaled by 256; they sum to exactly 256.
   localparam int unsigned LUMA_R = 77;
   localparam int unsigned LUMA_G = 150;
   localparam int unsigned LUMA_B = 29;

   // Two slots beyond the ROM latency cover one pixel held at the output
   // while a full pipe of reads is still landing.
   function automatic int fifo_depth(input int rom_lat);
      return rom_lat + 2;
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/raster_pixel_streamer_fifo.sv
// Show-ahead FIFO for the pixel stream: head entry is visible whenever not empty.
module pix_skid_fifo import raster_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   parameter int CNT_W = count_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             push_eff;
   logic             pop_eff;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o  = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop_eff  = pop_i && !empty_o;
   // A push into a full FIFO is accepted only when the head leaves in the same clock.
   assign push_eff = push_i && (!full || pop_eff);
   assign dout_o   = mem_q[rd_ptr_q];
   assign count_o  = count_q;

   always_comb begin
      wr_ptr_d = push_eff ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_eff  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push_eff, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_eff) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/raster_pixel_streamer.sv
// Raster-order frame buffer reader with valid/ready output and SOF/EOL/EOF sideband.
// Optional GRAYSCALE_EN macro converts each pixel to replicated luma at the FIFO write.
module raster_pixel_streamer import raster_pkg::*; #(
   parameter int IMG_W   = 400,
   parameter int IMG_H   = 266,
   parameter int PIX_W   = 24,
   parameter int ADDR_W  = 17,
   parameter int ROM_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              continuous_i,
   input  logic              stop_i,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              rom_en_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [PIX_W-1:0]  rom_data_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [PIX_W-1:0]  m_data_o,
   output logic              m_sof_o,
   output logic              m_eol_o,
   output logic              m_eof_o
);

   localparam int DEPTH = fifo_depth(ROM_LAT);
   localparam int CNT_W = count_width(DEPTH);
   localparam int OCC_W = CNT_W + 1;
   localparam int X_W   = $clog2(IMG_W);
   localparam int Y_W   = $clog2(IMG_H);
   localparam int SB_W  = $bits(sideband_t);
   localparam int FW    = PIX_W + SB_W;

   state_t                   state_q, state_d;
   logic [X_W-1:0]           x_q, x_d;
   logic [Y_W-1:0]           y_q, y_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic                     stop_q, stop_d;
   logic [ROM_LAT-1:0]       vld_q, vld_d;
   sideband_t [ROM_LAT-1:0]  sb_q, sb_d;

   sideband_t                issue_sb;
   sideband_t                out_sb;
   logic [PIX_W-1:0]         pix_wr;
   logic [FW-1:0]            fifo_dout;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_cnt;
   logic [OCC_W-1:0]         occupancy;
   logic                     last_pix;
   logic                     handshake;

`ifdef GRAYSCALE_EN
   localparam int CH_W = PIX_W / 3;
   localparam int LW   = CH_W + 8;
   logic [LW-1:0] luma_sum;

   assign luma_sum = LW'(LUMA_R) * LW'(rom_data_i[3*CH_W-1 -: CH_W])
                   + LW'(LUMA_G) * LW'(rom_data_i[2*CH_W-1 -: CH_W])
                   + LW'(LUMA_B) * LW'(rom_data_i[CH_W-1:0]);
   assign pix_wr   = {3{luma_sum[LW-1 -: CH_W]}};
`else
   assign pix_wr   = rom_data_i;
`endif

   // Every issued read owns a FIFO slot from issue until it is popped.
   assign occupancy = OCC_W'(fifo_cnt) + OCC_W'($countones(vld_q));
   assign last_pix  = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
   assign issue_sb  = '{sof: (x_q == '0) && (y_q == '0),
                        eol: (x_q == X_W'(IMG_W - 1)),
                        eof: last_pix};

   assign out_sb       = fifo_dout[FW-1:PIX_W];
   assign m_valid_o    = !fifo_empty;
   assign m_data_o     = fifo_dout[PIX_W-1:0];
   assign m_sof_o      = m_valid_o && out_sb.sof;
   assign m_eol_o      = m_valid_o && out_sb.eol;
   assign m_eof_o      = m_valid_o && out_sb.eof;
   assign handshake    = m_valid_o && m_ready_i;
   assign frame_done_o = handshake && out_sb.eof;
   assign busy_o       = (state_q != IDLE);
   assign rom_addr_o   = addr_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      addr_d   = addr_q;
      stop_d   = stop_q;
      rom_en_o = 1'b0;
      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            rom_en_o = (occupancy < OCC_W'(DEPTH));
            if (stop_i) begin
               stop_d = 1'b1;
            end
            if (rom_en_o) begin
               if (x_q == X_W'(IMG_W - 1)) begin
                  x_d = '0;
                  y_d = (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               addr_d = last_pix ? '0 : addr_q + 1'b1;
               if (last_pix && !(continuous_i && !stop_q && !stop_i)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (frame_done_o) begin
               state_d = IDLE;
               stop_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = rom_en_o;
      sb_d     = sb_q << SB_W;
      sb_d[0]  = issue_sb;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         addr_q  <= '0;
         stop_q  <= 1'b0;
         vld_q   <= '0;
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         stop_q  <= stop_d;
         vld_q   <= vld_d;
         sb_q    <= sb_d;
      end
   end

   pix_skid_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (vld_q[ROM_LAT-1]),
      .din_i   ({sb_q[ROM_LAT-1], pix_wr}),
      .pop_i   (m_ready_i),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_raster_pixel_streamer.sv
// Directed bench for raster_pixel_streamer: a 4x3 frame on a 1-clock ROM (dut a)
// and on a 3-clock ROM with random backpressure (dut b).
module tb_raster_pixel_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [23:0] rom_mem [16];

   logic        start_a, cont_a, stop_a, ready_a;
   logic        busy_a, done_a, en_a, valid_a, sof_a, eol_a, eof_a;
   logic [3:0]  addr_a;
   logic [23:0] rdata_a, data_a;

   logic        start_b, cont_b, stop_b, ready_b;
   logic        busy_b, done_b, en_b, valid_b, sof_b, eol_b, eof_b;
   logic [3:0]  addr_b;
   logic [23:0] rdata_b, data_b;
   logic [23:0] rpipe_b [3];

   always @(posedge clk) rdata_a <= rom_mem[addr_a];
   always @(posedge clk) begin
      rpipe_b[0] <= rom_mem[addr_b];
      rpipe_b[1] <= rpipe_b[0];
      rpipe_b[2] <= rpipe_b[1];
   end
   assign rdata_b = rpipe_b[2];

   raster_pixel_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(24), .ADDR_W(4), .ROM_LAT(1)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .continuous_i(cont_a), .stop_i(stop_a),
      .busy_o(busy_a), .frame_done_o(done_a), .rom_en_o(en_a), .rom_addr_o(addr_a),
      .rom_data_i(rdata_a), .m_valid_o(valid_a), .m_ready_i(ready_a), .m_data_o(data_a),
      .m_sof_o(sof_a), .m_eol_o(eol_a), .m_eof_o(eof_a));

   raster_pixel_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(24), .ADDR_W(4), .ROM_LAT(3)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .continuous_i(cont_b), .stop_i(stop_b),
      .busy_o(busy_b), .frame_done_o(done_b), .rom_en_o(en_b), .rom_addr_o(addr_b),
      .rom_data_i(rdata_b), .m_valid_o(valid_b), .m_ready_i(ready_b), .m_data_o(data_b),
      .m_sof_o(sof_b), .m_eol_o(eol_b), .m_eof_o(eof_b));

   function automatic logic [23:0] exp_pix(input logic [23:0] raw);
`ifdef GRAYSCALE_EN
      int y;
      y = (77 * int'(raw[23:16]) + 150 * int'(raw[15:8]) + 29 * int'(raw[7:0])) >> 8;
      return {3{y[7:0]}};
`else
      return raw;
`endif
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({valid_a, busy_a, en_a, done_a, sof_a, eol_a, eof_a} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags_a: got %b want 0000000", {valid_a, busy_a, en_a, done_a, sof_a, eol_a, eof_a});
      end
      checks++;
      if (addr_a !== 4'd0) begin
         errors++;
         $display("FAIL reset_addr_a: got %0d want 0", addr_a);
      end
      checks++;
      if ({valid_b, busy_b, en_b, done_b, sof_b, eol_b, eof_b} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags_b: got %b want 0000000", {valid_b, busy_b, en_b, done_b, sof_b, eol_b, eof_b});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Start sampled at edge 0; negedge of cycle c follows edge c-1.
   task automatic test_single_frame();
      logic [27:0] got, want;
      int p;
      ready_a = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         checks++;
         if (en_a !== (c <= 12)) begin
            errors++;
            $display("FAIL single_rom_en c=%0d: got %b want %b", c, en_a, (c <= 12));
         end
         if (c <= 12) begin
            checks++;
            if (addr_a !== 4'(c - 1)) begin
               errors++;
               $display("FAIL single_addr c=%0d: got %0d want %0d", c, addr_a, c - 1);
            end
         end
         checks++;
         if (valid_a !== (c >= 3 && c <= 14)) begin
            errors++;
            $display("FAIL single_valid c=%0d: got %b want %b", c, valid_a, (c >= 3 && c <= 14));
         end
         if (c >= 3 && c <= 14) begin
            p    = c - 3;
            got  = {data_a, sof_a, eol_a, eof_a, done_a};
            want = {exp_pix(rom_mem[p]), p == 0, p % 4 == 3, p == 11, p == 11};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL single_pixel p=%0d: got %h want %h", p, got, want);
            end
         end
         checks++;
         if (busy_a !== (c <= 14)) begin
            errors++;
            $display("FAIL single_busy c=%0d: got %b want %b", c, busy_a, (c <= 14));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [26:0] prev, got, want;
      logic        stalled;
      int          pix, issued;
      stalled = 1'b0;
      prev    = '0;
      pix     = 0;
      issued  = 0;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int cyc = 0; cyc < 400 && pix < 12; cyc++) begin
         got = {data_b, sof_b, eol_b, eof_b};
         if (en_b) issued++;
         checks++;
         if (issued - pix > 5) begin
            errors++;
            $display("FAIL bp_overflow cyc=%0d: outstanding %0d want <= 5", cyc, issued - pix);
         end
         if (stalled) begin
            checks++;
            if (!valid_b || got !== prev) begin
               errors++;
               $display("FAIL bp_stable cyc=%0d: got v=%b %h want v=1 %h", cyc, valid_b, got, prev);
            end
         end
         ready_b = 1'($urandom_range(0, 1));
         if (valid_b && ready_b) begin
            want = {exp_pix(rom_mem[pix]), pix == 0, pix % 4 == 3, pix == 11};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL bp_pixel p=%0d: got %h want %h", pix, got, want);
            end
            pix++;
         end
         stalled = valid_b && !ready_b;
         prev    = got;
         @(negedge clk);
      end
      checks++;
      if (pix != 12 || issued != 12) begin
         errors++;
         $display("FAIL bp_count: got %0d pixels %0d reads want 12 12", pix, issued);
      end
      ready_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle: got busy=%b valid=%b want 0 0", busy_b, valid_b);
      end
   endtask

   task automatic test_continuous();
      logic [26:0] got, want;
      int          wait_cyc;
      ready_a  = 1'b1;
      cont_a   = 1'b1;
      start_a  = 1'b1;
      @(negedge clk);
      start_a  = 1'b0;
      wait_cyc = 0;
      while (!valid_a && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      checks++;
      if (!valid_a) begin
         errors++;
         $display("FAIL cont_first_valid: got 0 after %0d cycles want 1", wait_cyc);
      end
      for (int i = 0; i < 36; i++) begin
         got  = {data_a, sof_a, eof_a, done_a};
         want = {exp_pix(rom_mem[i % 12]), i % 12 == 0, i % 12 == 11, i % 12 == 11};
         checks++;
         if (valid_a !== 1'b1 || got !== want) begin
            errors++;
            $display("FAIL cont_pixel i=%0d: got v=%b %h want v=1 %h", i, valid_a, got, want);
         end
         if (i == 24) cont_a = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
         errors++;
         $display("FAIL cont_end: got busy=%b valid=%b want 0 0", busy_a, valid_a);
      end
   endtask

   task automatic test_stop();
      int pix, issued, eof_cyc;
      pix     = 0;
      issued  = 0;
      eof_cyc = -10;
      ready_a = 1'b1;
      cont_a  = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (en_a) issued++;
         stop_a = valid_a && (pix == 16);
         if (cyc == eof_cyc + 1) begin
            checks++;
            if (busy_a !== 1'b0) begin
               errors++;
               $display("FAIL stop_busy_drop cyc=%0d: got %b want 0", cyc, busy_a);
            end
         end
         if (valid_a) begin
            checks++;
            if (data_a !== exp_pix(rom_mem[pix % 12]) || eof_a !== (pix % 12 == 11)) begin
               errors++;
               $display("FAIL stop_pixel p=%0d: got %h eof=%b want %h eof=%b", pix, data_a, eof_a,
                        exp_pix(rom_mem[pix % 12]), (pix % 12 == 11));
            end
            if (pix == 23) begin
               eof_cyc = cyc;
               checks++;
               if (busy_a !== 1'b1) begin
                  errors++;
                  $display("FAIL stop_busy_at_eof: got %b want 1", busy_a);
               end
            end
            pix++;
         end
         @(negedge clk);
      end
      stop_a = 1'b0;
      cont_a = 1'b0;
      checks++;
      if (pix != 24 || issued != 24) begin
         errors++;
         $display("FAIL stop_count: got %0d pixels %0d reads want 24 24", pix, issued);
      end
   endtask

   task automatic test_reset_mid_frame();
      int wait_cyc;
      ready_a = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre_valid: got %b want 1", valid_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({valid_a, busy_a, en_a, sof_a, eol_a, eof_a, done_a} !== 7'b0 || addr_a !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_async_clear: got flags=%b addr=%0d want 0 0",
                  {valid_a, busy_a, en_a, sof_a, eol_a, eof_a, done_a}, addr_a);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || sof_a !== 1'b1 || data_a !== exp_pix(rom_mem[0])) begin
         errors++;
         $display("FAIL rstmid_restart: got v=%b sof=%b %h want v=1 sof=1 %h", valid_a, sof_a, data_a,
                  exp_pix(rom_mem[0]));
      end
      wait_cyc = 0;
      while (busy_a && wait_cyc < 30) begin
         @(negedge clk);
         wait_cyc++;
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_drain: got busy=%b want 0", busy_a);
      end
   endtask

   task automatic test_pixel_format();
      logic [23:0] want [3];
`ifdef GRAYSCALE_EN
      want[0] = 24'h4C4C4C;
      want[1] = 24'hFFFFFF;
      want[2] = 24'h2D2D2D;
`else
      want[0] = 24'hFF0000;
      want[1] = 24'hFFFFFF;
      want[2] = 24'h123456;
`endif
      rom_mem[0] = 24'hFF0000;
      rom_mem[1] = 24'hFFFFFF;
      rom_mem[2] = 24'h123456;
      ready_a = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (valid_a !== 1'b1 || data_a !== want[k]) begin
            errors++;
            $display("FAIL format_pixel k=%0d: got v=%b %h want v=1 %h", k, valid_a, data_a, want[k]);
         end
      end
      repeat (14) @(negedge clk);
      for (int i = 0; i < 16; i++) rom_mem[i] = 24'(i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) rom_mem[i] = 24'(i);
      {start_a, cont_a, stop_a, ready_a} = 4'b0;
      {start_b, cont_b, stop_b, ready_b} = 4'b0;
      rst = 1'b1;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_continuous();
      test_stop();
      repeat (3) @(negedge clk);
      test_reset_mid_frame();
      test_pixel_format();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
